stage_1_fetch: RTL

Instruction-fetch stage, directly upstream of the decode/register-read stage. Owns the PC and runs a request/acknowledge handshake to instruction memory. Holds the fetched instruction and presents its decoded fields (op, rs, rt, rd, imm, func) until downstream signals retirement. Computes the next PC from the branch/j/jr controls returned by decode and execute.

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/stage_1_next_pc.sv | 43 ++++
 rtl/stage_1_fetch.sv | 126 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, reset PC and
// instruction field bit positions.
package cpu_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      HOLD
   } state_e;

   localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

   localparam int OP_HI   = 31;
   localparam int OP_LO   = 26;
   localparam int RS_HI   = 25;
   localparam int RS_LO   = 21;
   localparam int RT_HI   = 20;
   localparam int RT_LO   = 16;
   localparam int RD_HI   = 15;
   localparam int RD_LO   = 11;
   localparam int IMM_HI  = 15;
   localparam int IMM_LO  = 0;
   localparam int FUNC_HI = 5;
   localparam int FUNC_LO = 0;
   localparam int JIDX_HI = 25;
   localparam int JIDX_LO = 0;

endpackage

// File: rtl/stage_1_next_pc.sv
// Next-PC selection for the fetch stage: jr > j > taken branch > pc+4.
// Purely combinational; misalign flags a jr target with low bits set.
module stage_1_next_pc
   import cpu_pkg::*;
(
   input  logic [31:0] pc_plus_4,
   input  logic [31:0] ir,
   input  logic        branch,
   input  logic        zero,
   input  logic        j,
   input  logic        jr,
   input  logic [31:0] jr_target,
   output logic [31:0] next_pc,
   output logic        misalign
);

   logic [31:0] br_off;
   logic [31:0] br_pc;
   logic [31:0] j_pc;
   logic [31:0] jr_pc;
   logic        unused_op;

   assign unused_op = ^ir[OP_HI:OP_LO];

   assign br_off = {{14{ir[IMM_HI]}}, ir[IMM_HI:IMM_LO], 2'b00};
   assign br_pc  = pc_plus_4 + br_off;
   assign j_pc   = {pc_plus_4[31:28], ir[JIDX_HI:JIDX_LO], 2'b00};
   assign jr_pc  = {jr_target[31:2], 2'b00};

   always_comb begin
      next_pc  = pc_plus_4;
      misalign = 1'b0;
      if (jr) begin
         next_pc  = jr_pc;
         misalign = |jr_target[1:0];
      end else if (j) begin
         next_pc = j_pc;
      end else if (branch && zero) begin
         next_pc = br_pc;
      end
   end

endmodule

// File: rtl/stage_1_fetch.sv
// Instruction fetch stage: owns the PC, runs the imem req/ack handshake
// and holds the fetched word for decode until it retires.
module stage_1_fetch
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter int          MAX_WAIT = 16
) (
   input  logic        clock,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   input  logic        instr_done,
   input  logic        branch,
   input  logic        zero,
   input  logic        j,
   input  logic        jr,
   input  logic [31:0] jr_target,
   output logic [5:0]  op,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  rd,
   output logic [15:0] imm,
   output logic [5:0]  func,
   output logic [31:0] pc,
   output logic [31:0] pc_plus_4,
   output logic        fetch_err
);

   localparam int CW = $clog2(MAX_WAIT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(MAX_WAIT - 1);

   state_e          state_q, state_d;
   logic [31:0]     pc_q, pc_d;
   logic [31:0]     ir_q, ir_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            err_q, err_d;
   logic            req_q, req_d;
   logic            vld_q, vld_d;
   logic [31:0]     next_pc;
   logic            misalign;

   assign pc_plus_4 = pc_q + 32'd4;

   stage_1_next_pc u_next_pc (
      .pc_plus_4 (pc_plus_4),
      .ir        (ir_q),
      .branch    (branch),
      .zero      (zero),
      .j         (j),
      .jr        (jr),
      .jr_target (jr_target),
      .next_pc   (next_pc),
      .misalign  (misalign)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      unique case (state_q)
         IDLE: state_d = REQ;
         REQ: begin
            if (imem_ack) begin
               ir_d    = imem_rdata;
               cnt_d   = '0;
               state_d = HOLD;
            end else if (cnt_q == CNT_LAST) begin
               // Saturate and keep requesting; the error is only a flag.
               err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         HOLD: begin
            if (instr_done) begin
               pc_d    = next_pc;
               state_d = REQ;
               if (misalign) err_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      req_d = (state_d == REQ);
      vld_d = (state_d == HOLD);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         ir_q    <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         req_q   <= 1'b0;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         req_q   <= req_d;
         vld_q   <= vld_d;
      end
   end

   assign imem_req    = req_q;
   assign imem_addr   = pc_q;
   assign instr_valid = vld_q;
   assign pc          = pc_q;
   assign fetch_err   = err_q;

   assign op   = ir_q[OP_HI:OP_LO];
   assign rs   = ir_q[RS_HI:RS_LO];
   assign rt   = ir_q[RT_HI:RT_LO];
   assign rd   = ir_q[RD_HI:RD_LO];
   assign imm  = ir_q[IMM_HI:IMM_LO];
   assign func = ir_q[FUNC_HI:FUNC_LO];

endmodule
